// File: rtl/alu_mult_sequencer.sv
// Iterative radix-2 Booth multiplier that borrows the shared ALU for its add/sub
// steps and otherwise passes the execute-stage ALU request straight through.
module alu_mult_sequencer #(
  parameter int WIDTH = 32,
  parameter int STEPS = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic [WIDTH-1:0] exe_operandA,
  input  logic [WIDTH-1:0] exe_operandB,
  input  logic [4:0]       exe_opcode,
  input  logic [4:0]       exe_shamt,
  output logic [WIDTH-1:0] alu_operandA,
  output logic [WIDTH-1:0] alu_operandB,
  output logic [4:0]       alu_opcode,
  output logic [4:0]       alu_shamt,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  output logic             stall_exe,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int CW = $clog2(STEPS);

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] p_hi;
  logic [WIDTH-1:0] p_lo;
  logic             q_1;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] result_q;
  logic             exc_q;

  logic             sum_sign;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;
  logic             last_step;

  // The ALU's 32-bit sum can wrap; xor with overflow recovers the true sign
  // of the 33-bit sum so the arithmetic shift stays correct near -2^31.
  always_comb begin
    sum_sign  = alu_result[WIDTH-1] ^ alu_overflow;
    hi_next   = {sum_sign, alu_result[WIDTH-1:1]};
    lo_next   = {alu_result[0], p_lo[WIDTH-1:1]};
    last_step = (count == CW'(STEPS - 1));
  end

  always_comb begin
    state_next   = state;
    alu_operandA = exe_operandA;
    alu_operandB = exe_operandB;
    alu_opcode   = exe_opcode;
    alu_shamt    = exe_shamt;
    case (state)
      IDLE: begin
        if (ctrl_MULT) state_next = RUN;
      end
      RUN: begin
        alu_operandA = p_hi;
        alu_operandB = '0;
        alu_opcode   = OP_ADD;
        alu_shamt    = '0;
        case ({p_lo[0], q_1})
          2'b01: alu_operandB = m;
          2'b10: begin
            alu_operandB = m;
            alu_opcode   = OP_SUB;
          end
          default: ;
        endcase
        if (last_step) state_next = DONE;
      end
      DONE: begin
        state_next = ctrl_MULT ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Result and exception are captured on the final step so they are valid
  // during DONE and hold until the next product completes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      m        <= '0;
      p_hi     <= '0;
      p_lo     <= '0;
      q_1      <= 1'b0;
      count    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE, DONE: begin
          if (ctrl_MULT) begin
            m     <= data_operandA;
            p_hi  <= '0;
            p_lo  <= data_operandB;
            q_1   <= 1'b0;
            count <= '0;
          end
        end
        RUN: begin
          p_hi  <= hi_next;
          p_lo  <= lo_next;
          q_1   <= p_lo[0];
          count <= count + 1'b1;
          if (last_step) begin
            result_q <= lo_next;
            exc_q    <= (hi_next != {WIDTH{lo_next[WIDTH-1]}});
          end
        end
        default: ;
      endcase
    end
  end

  assign stall_exe      = (state == RUN);
  assign data_resultRDY = (state == DONE);
  assign data_result    = result_q;
  assign data_exception = exc_q;

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Directed bench for alu_mult_sequencer with a behavioural model of the
// shared add/sub ALU closing the loop.
module tb_alu_mult_sequencer;

  logic        clock;
  logic        reset;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] exe_operandA;
  logic [31:0] exe_operandB;
  logic [4:0]  exe_opcode;
  logic [4:0]  exe_shamt;
  logic [31:0] alu_operandA;
  logic [31:0] alu_operandB;
  logic [4:0]  alu_opcode;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_result;
  logic        alu_overflow;
  logic        stall_exe;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int errors;
  int checks;

  alu_mult_sequencer dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .exe_operandA   (exe_operandA),
    .exe_operandB   (exe_operandB),
    .exe_opcode     (exe_opcode),
    .exe_shamt      (exe_shamt),
    .alu_operandA   (alu_operandA),
    .alu_operandB   (alu_operandB),
    .alu_opcode     (alu_opcode),
    .alu_shamt      (alu_shamt),
    .alu_result     (alu_result),
    .alu_overflow   (alu_overflow),
    .stall_exe      (stall_exe),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Shared ALU: 00000 add, 00001 subtract, signed overflow flag.
  always_comb begin
    alu_result   = '0;
    alu_overflow = 1'b0;
    case (alu_opcode)
      5'b00000: begin
        alu_result   = alu_operandA + alu_operandB;
        alu_overflow = (alu_operandA[31] == alu_operandB[31]) &&
                       (alu_result[31] != alu_operandA[31]);
      end
      5'b00001: begin
        alu_result   = alu_operandA - alu_operandB;
        alu_overflow = (alu_operandA[31] != alu_operandB[31]) &&
                       (alu_result[31] != alu_operandA[31]);
      end
      default: ;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = 1'b1;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
  endtask

  // Counts posedges until RDY is seen; -1 if it never arrives.
  task automatic waitRdy(output int edges);
    edges = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic runCase(input string tag, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input logic exp_exc);
    int e;
    applyStimulus(a, b);
    waitRdy(e);
    checkOutput({tag, "_lat"}, 64'(e), 64'd32);
    checkOutput({tag, "_res"}, 64'(data_result), 64'(exp_res));
    checkOutput({tag, "_exc"}, 64'(data_exception), 64'(exp_exc));
    @(posedge clock);
    #1;
    checkOutput({tag, "_rdy_drop"}, 64'(data_resultRDY), 64'd0);
    checkOutput({tag, "_hold"}, 64'(data_result), 64'(exp_res));
  endtask

  initial begin
    int e;
    int seen_rdy;
    errors        = 0;
    checks        = 0;
    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    exe_operandA  = '0;
    exe_operandB  = '0;
    exe_opcode    = '0;
    exe_shamt     = '0;

    repeat (2) @(negedge clock);
    checkOutput("rst_stall", 64'(stall_exe), 64'd0);
    checkOutput("rst_rdy", 64'(data_resultRDY), 64'd0);
    checkOutput("rst_res", 64'(data_result), 64'd0);
    checkOutput("rst_exc", 64'(data_exception), 64'd0);
    reset = 1'b0;

    // Idle pass-through of the execute request
    exe_opcode   = 5'b00001;
    exe_operandA = 32'd10;
    exe_operandB = 32'd3;
    exe_shamt    = 5'd4;
    #1;
    checkOutput("idle_opA", 64'(alu_operandA), 64'd10);
    checkOutput("idle_opB", 64'(alu_operandB), 64'd3);
    checkOutput("idle_op", 64'(alu_opcode), 64'd1);
    checkOutput("idle_shamt", 64'(alu_shamt), 64'd4);
    checkOutput("idle_stall", 64'(stall_exe), 64'd0);

    // 3*4 with the sequencer owning the ALU: steps 1-2 add 0, step 3 subtracts M
    applyStimulus(32'd3, 32'd4);
    checkOutput("run_stall", 64'(stall_exe), 64'd1);
    checkOutput("run_opA", 64'(alu_operandA), 64'd0);
    checkOutput("run_opB", 64'(alu_operandB), 64'd0);
    checkOutput("run_op", 64'(alu_opcode), 64'd0);
    checkOutput("run_shamt", 64'(alu_shamt), 64'd0);
    repeat (2) @(posedge clock);
    #1;
    checkOutput("run_sub_op", 64'(alu_opcode), 64'd1);
    checkOutput("run_sub_opB", 64'(alu_operandB), 64'd3);
    waitRdy(e);
    checkOutput("m3x4_lat", 64'(e + 2), 64'd32);
    checkOutput("m3x4_res", 64'(data_result), 64'd12);
    checkOutput("m3x4_exc", 64'(data_exception), 64'd0);
    checkOutput("done_stall", 64'(stall_exe), 64'd0);
    checkOutput("done_passA", 64'(alu_operandA), 64'd10);

    runCase("m_7x6", 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6, 1'b0);
    runCase("m6x_7", 32'd6, 32'hFFFF_FFF9, 32'hFFFF_FFD6, 1'b0);
    runCase("m2p16sq", 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
    runCase("mmin_x_1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    runCase("mmin_x1", 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);
    runCase("mmin_sq", 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1);

    // Asynchronous abort after 10 RUN steps
    applyStimulus(32'd9, 32'd9);
    repeat (10) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("abort_stall", 64'(stall_exe), 64'd0);
    checkOutput("abort_rdy", 64'(data_resultRDY), 64'd0);
    @(negedge clock);
    reset    = 1'b0;
    seen_rdy = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) seen_rdy = 1;
    end
    checkOutput("abort_no_rdy", 64'(seen_rdy), 64'd0);

    // Back-to-back: 5*5 starts in the DONE cycle of 2*3
    applyStimulus(32'd2, 32'd3);
    waitRdy(e);
    checkOutput("b2b_first_lat", 64'(e), 64'd32);
    checkOutput("b2b_first_res", 64'(data_result), 64'd6);
    data_operandA = 32'd5;
    data_operandB = 32'd5;
    ctrl_MULT     = 1'b1;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    checkOutput("b2b_restart", 64'(stall_exe), 64'd1);
    waitRdy(e);
    checkOutput("b2b_lat", 64'(e), 64'd32);
    checkOutput("b2b_res", 64'(data_result), 64'd25);
    checkOutput("b2b_exc", 64'(data_exception), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
